dmem_arbiter: RTL and testbench

- Shares the single-port data memory (sync write, combinational read) between the MIPS core data port (requester 0, CPU) and an auxiliary master (requester 1, AUX: loader/debug/DMA).
- Sits between `mips` data-side signals and `dmem`.
- CPU has priority; an aging counter guarantees AUX forward progress.
- Stalls the CPU when it loses arbitration and keeps performance counters for the bench.

---
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the single-port data memory between the CPU data port
//            (requester 0, priority) and an auxiliary master (requester 1).
//            An aging counter guarantees AUX forward progress; the CPU is
//            stalled when it loses. Conflict and stall cycles are counted.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDRBITS  = 14,
    parameter int AGE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active-low
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDRBITS-1:0] cpu_addr,
    input  logic [WIDTH-1:0]    cpu_wdata,
    output logic [WIDTH-1:0]    cpu_rdata,
    output logic                cpu_stall,
    input  logic                aux_req,
    input  logic                aux_we,
    input  logic [ADDRBITS-1:0] aux_addr,
    input  logic [WIDTH-1:0]    aux_wdata,
    output logic [WIDTH-1:0]    aux_rdata,
    output logic                aux_ack,
    output logic                mem_we,
    output logic [ADDRBITS-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic [WIDTH-1:0]    conflict_cnt,
    output logic [WIDTH-1:0]    stall_cnt
);

    localparam logic [3:0] c_AGE_LIMIT = 4'(AGE_LIMIT);

    logic [3:0]       r_age;
    logic             r_last_aux;
    logic [WIDTH-1:0] r_conflict_cnt;
    logic [WIDTH-1:0] r_stall_cnt;

    logic w_age_win;
    logic w_aux_grant;
    logic w_cpu_grant;

    // Grant decision; everything is qualified by rst so the memory port and
    // handshakes stay quiet while reset is held (suppresses in-flight writes).
    always_comb begin
        w_age_win   = (r_age == c_AGE_LIMIT) & ~r_last_aux;
        w_aux_grant = rst & aux_req & (~cpu_req | w_age_win);
        w_cpu_grant = rst & cpu_req & ~w_aux_grant;
    end

    // Memory mux and requester-side responses.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        aux_rdata = '0;
        if (w_aux_grant) begin
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            aux_rdata = mem_rdata;
        end else if (w_cpu_grant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end
        cpu_stall    = rst & cpu_req & ~w_cpu_grant;
        aux_ack      = w_aux_grant;
        conflict_cnt = r_conflict_cnt;
        stall_cnt    = r_stall_cnt;
    end

    // Aging state: count AUX waiting cycles (saturating), remember an AUX win
    // that displaced the CPU so AUX cannot win twice in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_age      <= 4'd0;
            r_last_aux <= 1'b0;
        end else begin
            if (aux_req & ~w_aux_grant) begin
                if (r_age != c_AGE_LIMIT) begin
                    r_age <= r_age + 4'd1;
                end
            end else begin
                r_age <= 4'd0;
            end
            r_last_aux <= w_aux_grant & cpu_req;
        end
    end

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (cpu_req & aux_req) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
            if (cpu_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter. A driver issues directed and
//            random traffic and pushes reference-model expectations; a monitor
//            pops and compares once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int WIDTH     = 32;
    localparam int ADDRBITS  = 14;
    localparam int AGE_LIMIT = 4;
    localparam int DEPTH     = 1 << ADDRBITS;

    logic                clk = 1'b0;
    logic                rst;
    logic                cpu_req, cpu_we, aux_req, aux_we;
    logic [ADDRBITS-1:0] cpu_addr, aux_addr, mem_addr;
    logic [WIDTH-1:0]    cpu_wdata, aux_wdata, cpu_rdata, aux_rdata;
    logic                cpu_stall, aux_ack, mem_we;
    logic [WIDTH-1:0]    mem_wdata, mem_rdata, conflict_cnt, stall_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(WIDTH), .ADDRBITS(ADDRBITS), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_rdata(aux_rdata), .aux_ack(aux_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
    );

    // Data memory: synchronous write, combinational read.
    logic [WIDTH-1:0] dmem [0:DEPTH-1];
    assign mem_rdata = dmem[mem_addr];
    always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

    typedef struct {
        logic                stall;
        logic                ack;
        logic                we;
        logic [ADDRBITS-1:0] addr;
        logic [WIDTH-1:0]    crd;
        logic [WIDTH-1:0]    ard;
        logic [WIDTH-1:0]    conf;
        logic [WIDTH-1:0]    stl;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic [WIDTH-1:0] ref_mem [0:DEPTH-1];
    int               aux_wait;
    bit               aux_won_over_cpu;
    logic [WIDTH-1:0] m_conf, m_stl;
    bit               m_last_stall, m_last_ack;

    task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; model computes the expected response.
    task automatic step(input bit r, input bit cr, input bit cw, input logic [ADDRBITS-1:0] ca,
                        input logic [WIDTH-1:0] cd, input bit ar, input bit aw,
                        input logic [ADDRBITS-1:0] aa, input logic [WIDTH-1:0] ad);
        exp_t e;
        bit   aux_wins, cpu_wins;
        @(negedge clk);
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
        e = '{stall: 1'b0, ack: 1'b0, we: 1'b0, addr: '0, crd: '0, ard: '0, conf: '0, stl: '0};
        if (!r) begin
            aux_wait = 0; aux_won_over_cpu = 1'b0;
            m_conf = '0; m_stl = '0; m_last_stall = 1'b0; m_last_ack = 1'b0;
        end else begin
            aux_wins = ar && (!cr || (aux_wait == AGE_LIMIT && !aux_won_over_cpu));
            cpu_wins = cr && !aux_wins;
            e.stall = cr && !cpu_wins;
            e.ack   = aux_wins;
            e.we    = (aux_wins && aw) || (cpu_wins && cw);
            e.addr  = aux_wins ? aa : (cpu_wins ? ca : '0);
            e.crd   = cpu_wins ? ref_mem[ca] : '0;
            e.ard   = aux_wins ? ref_mem[aa] : '0;
            e.conf  = m_conf;
            e.stl   = m_stl;
            if (aux_wins && aw) ref_mem[aa] = ad;
            else if (cpu_wins && cw) ref_mem[ca] = cd;
            if (cr && ar) m_conf = m_conf + 1;
            if (e.stall) m_stl = m_stl + 1;
            if (ar && !aux_wins) aux_wait = (aux_wait < AGE_LIMIT) ? aux_wait + 1 : aux_wait;
            else aux_wait = 0;
            aux_won_over_cpu = aux_wins && cr;
            m_last_stall = e.stall;
            m_last_ack   = aux_wins;
        end
        expq.push_back(e);
    endtask

    // Monitor: compare the DUT outputs of each cycle before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("cpu_stall",    {31'b0, cpu_stall}, {31'b0, e.stall});
                check("aux_ack",      {31'b0, aux_ack},   {31'b0, e.ack});
                check("mem_we",       {31'b0, mem_we},    {31'b0, e.we});
                check("mem_addr",     {18'b0, mem_addr},  {18'b0, e.addr});
                check("cpu_rdata",    cpu_rdata,    e.crd);
                check("aux_rdata",    aux_rdata,    e.ard);
                check("conflict_cnt", conflict_cnt, e.conf);
                check("stall_cnt",    stall_cnt,    e.stl);
            end
        end
    end

    // Driver
    initial begin
        bit                  cr, cw, ar, aw;
        logic [ADDRBITS-1:0] ca, aa;
        logic [WIDTH-1:0]    cd, ad;
        int                  acks;

        for (int i = 0; i < DEPTH; i++) begin
            dmem[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;
        aux_wait = 0; aux_won_over_cpu = 1'b0; m_conf = '0; m_stl = '0;
        m_last_stall = 1'b0; m_last_ack = 1'b0;

        // Reset held with both requesting
        step(0, 1, 1, 14'd1, 32'h1111_1111, 1, 1, 14'd2, 32'h2222_2222);
        step(0, 1, 1, 14'd1, 32'h1111_1111, 1, 1, 14'd2, 32'h2222_2222);
        #4;
        check("rst_mem_we",  {31'b0, mem_we},    32'd0);
        check("rst_aux_ack", {31'b0, aux_ack},   32'd0);
        check("rst_stall",   {31'b0, cpu_stall}, 32'd0);

        // Sustained contention from reset release: CPU first, AUX on cycle 5,
        // never AUX twice in a row, CPU stalls exactly on AUX grant cycles.
        acks = 0;
        aa = 14'd200;
        for (int k = 1; k <= 20; k++) begin
            step(1, 1, 0, 14'(k), '0, 1, 1, aa, 32'hA000_0000 + 32'(k));
            #4;
            if (k <= 6) check("contend_ack_cycle", {31'b0, aux_ack}, {31'b0, (k == 5)});
            check("contend_stall_eq_ack", {31'b0, cpu_stall}, {31'b0, aux_ack});
            if (aux_ack) begin
                acks++;
                aa = aa + 1;
            end
        end
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        #4;
        check("contend_conflict_cnt", conflict_cnt, 32'd20);
        check("contend_stall_cnt",    stall_cnt,    32'(acks));

        // CPU-only store then load
        step(1, 1, 1, 14'd5, 32'hDEAD_BEEF, 0, 0, '0, '0);
        #4; check("cpu_store_we", {31'b0, mem_we}, 32'd1);
        step(1, 1, 0, 14'd5, '0, 0, 0, '0, '0);
        #4; check("cpu_load_data", cpu_rdata, 32'hDEAD_BEEF);
        check("cpu_load_we", {31'b0, mem_we}, 32'd0);

        // AUX-only store, CPU reads it back
        step(1, 0, 0, '0, '0, 1, 1, 14'd3, 32'h1234_5678);
        #4; check("aux_store_ack", {31'b0, aux_ack}, 32'd1);
        step(1, 1, 0, 14'd3, '0, 0, 0, '0, '0);
        #4; check("cpu_load_aux_data", cpu_rdata, 32'h1234_5678);

        // Reset in the middle of an AUX store suppresses the write
        step(1, 1, 1, 14'd7, 32'hA5A5_A5A5, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, 1, 1, 14'd7, 32'hBAD0_BAD0);
        #4; check("midrst_aux_ack", {31'b0, aux_ack}, 32'd0);
        check("midrst_mem_we", {31'b0, mem_we}, 32'd0);
        step(1, 1, 0, 14'd7, '0, 0, 0, '0, '0);
        #4; check("midrst_mem_kept", cpu_rdata, 32'hA5A5_A5A5);
        check("midrst_conflict_cnt", conflict_cnt, 32'd0);

        // Randomized traffic obeying the hold protocols
        cr = 0; cw = 0; ca = '0; cd = '0; ar = 0; aw = 0; aa = '0; ad = '0;
        for (int i = 0; i < 400; i++) begin
            if (!m_last_stall) begin
                cr = ($urandom_range(0, 99) < 70);
                cw = $urandom_range(0, 1) == 1;
                ca = 14'($urandom_range(0, 15));
                cd = $urandom;
            end
            if (!ar || m_last_ack) begin
                ar = ($urandom_range(0, 99) < 55);
                aw = $urandom_range(0, 1) == 1;
                aa = 14'($urandom_range(0, 15));
                ad = $urandom;
            end
            if (i % 97 == 50) begin
                step(0, cr, cw, ca, cd, ar, aw, aa, ad);
                cr = 0; ar = 0;
            end else begin
                step(1, cr, cw, ca, cd, ar, aw, aa, ad);
            end
        end
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && expq.size() > 0; w++) @(negedge clk);
        #5;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
